// File: rtl/mx_format_pkg.sv
// Shared MX format definitions: block geometry, element format codes and
// per-format helpers used by the MX ALU front-end.
package mx_format_pkg;

    localparam int SCALING_BLOCK_SIZE  = 32;
    localparam int SCALE_BITS          = 8;
    localparam int ELEM_REGION_BITS    = 256;
    localparam int LARGEST_VECTOR_SIZE = ELEM_REGION_BITS + SCALE_BITS;

    // Element format codes; 6 and 7 are unassigned and treated as illegal.
    typedef enum logic [2:0] {
        MX_E5M2 = 3'd0,
        MX_E4M3 = 3'd1,
        MX_E3M2 = 3'd2,
        MX_E2M3 = 3'd3,
        MX_E2M1 = 3'd4,
        MX_INT8 = 3'd5
    } t_mx_format;

    // Element width in bits; illegal codes fall back to the widest layout.
    function automatic logic [3:0] mx_elem_bits(t_mx_format fmt);
        case (fmt)
            MX_E3M2, MX_E2M3: mx_elem_bits = 4'd6;
            MX_E2M1:          mx_elem_bits = 4'd4;
            default:          mx_elem_bits = 4'd8;
        endcase
    endfunction

    function automatic logic mx_fmt_legal(t_mx_format fmt);
        case (fmt)
            MX_E5M2, MX_E4M3, MX_E3M2, MX_E2M3, MX_E2M1, MX_INT8: mx_fmt_legal = 1'b1;
            default:                                              mx_fmt_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mx_vector_loader.sv
// Deserializes one MX block (scale beat + W element beats) from a 32-bit
// valid/ready stream into a single 264-bit vector held until consumed.
module mx_vector_loader
    import mx_format_pkg::*;
#(
    parameter int  IN_WIDTH  = SCALING_BLOCK_SIZE,
    localparam int VEC_WIDTH = LARGEST_VECTOR_SIZE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic [2:0]           in_fmt,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [VEC_WIDTH-1:0] out_vector,
    output logic [2:0]           out_fmt,
    output logic                 out_err
);

    // Beat placement assumes one word per 32-element scaling block row.
    if (IN_WIDTH != SCALING_BLOCK_SIZE) begin : g_width_check
        $error("mx_vector_loader: IN_WIDTH must equal SCALING_BLOCK_SIZE (32)");
    end

    typedef enum logic [1:0] {
        ST_SCALE = 2'd0,
        ST_ELEMS = 2'd1,
        ST_FULL  = 2'd2
    } t_state;

    t_state               state_q;
    t_state               state_d;
    logic [2:0]           cnt_q;
    logic [VEC_WIDTH-1:0] vec_q;
    logic [2:0]           fmt_q;
    logic                 err_q;

    logic                 in_fire;
    logic [3:0]           elem_bits;
    logic                 last_beat;

    // Handshake flags depend on the state register only.
    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q == ST_FULL);
    assign in_fire   = in_valid && in_ready;

    // Beat count equals element width, taken from the latched format.
    assign elem_bits = mx_elem_bits(t_mx_format'(fmt_q));
    assign last_beat = ({1'b0, cnt_q} == (elem_bits - 4'd1));

    assign out_vector = vec_q;
    assign out_fmt    = fmt_q;
    assign out_err    = err_q;

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q <= ST_SCALE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: scale beat, W element beats, then hold until drained.
    always_comb begin
        // NOTE: default first so no path through the case leaves state_d
        // unassigned, which would otherwise infer a latch.
        state_d = state_q;
        case (state_q)
            ST_SCALE: if (in_fire)              state_d = ST_ELEMS;
            ST_ELEMS: if (in_fire && last_beat) state_d = ST_FULL;
            ST_FULL:  if (out_ready)            state_d = ST_SCALE;
            default:                            state_d = ST_SCALE;
        endcase
    end

    // Datapath: latch scale/format on the scale beat, then fill element words.
    always_ff @(posedge clk) begin
        // NOTE: the vector is plain flops, not a RAM, so it is reset along
        // with the control state; a partial block never survives reset.
        if (!rst_n) begin
            vec_q <= '0;
            cnt_q <= '0;
            fmt_q <= '0;
            err_q <= 1'b0;
        end else if (in_fire) begin
            if (state_q == ST_SCALE) begin
                vec_q <= {in_data[SCALE_BITS-1:0], {ELEM_REGION_BITS{1'b0}}};
                fmt_q <= in_fmt;
                err_q <= !mx_fmt_legal(t_mx_format'(in_fmt));
                cnt_q <= '0;
            end else begin
                vec_q[{cnt_q, 5'b00000} +: IN_WIDTH] <= in_data;
                cnt_q <= cnt_q + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_mx_vector_loader.sv
// Self-checking bench for mx_vector_loader: directed blocks plus randomized
// blocks compared against an element-level reference model.
module tb_mx_vector_loader;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic [2:0]   in_fmt;
    logic         out_valid;
    logic         out_ready;
    logic [263:0] out_vector;
    logic [2:0]   out_fmt;
    logic         out_err;

    int total;
    int bad;

    mx_vector_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_fmt     (in_fmt),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_vector (out_vector),
        .out_fmt    (out_fmt),
        .out_err    (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [263:0] got, input logic [263:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: element width by format code.
    function automatic int ref_width(input logic [2:0] fmt);
        case (fmt)
            3'd2, 3'd3: return 6;
            3'd4:       return 4;
            default:    return 8;
        endcase
    endfunction

    // Reference: place 32 elements of w bits each, element k at bit k*w.
    function automatic logic [255:0] pack_elems(input int el[32], input int w);
        logic [255:0] r;
        r = '0;
        for (int k = 0; k < 32; k++)
            for (int b = 0; b < w; b++)
                r[k*w + b] = el[k][b];
        return r;
    endfunction

    // Present one word and wait (bounded) for its handshake.
    task automatic send_word(input logic [31:0] data, input logic [2:0] fmt, input int gap);
        logic acc;
        int   n;
        repeat (gap) begin
            in_valid = 1'b0;
            in_data  = $urandom;
            in_fmt   = 3'($urandom);
            tick();
        end
        in_valid = 1'b1;
        in_data  = data;
        in_fmt   = fmt;
        n = 0;
        forever begin
            acc = in_ready;
            tick();
            if (acc) break;
            n++;
            if (n > 50) begin
                check("hs_timeout", 264'(0), 264'(1));
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    // Send a full block whose element beats come from region; checks the
    // assembled result and returns the expected vector for drain checks.
    task automatic send_block(input logic [7:0] scale, input logic [2:0] fmt,
                              input logic [255:0] region, input int gap_max,
                              output logic [263:0] exp_vec);
        int           w;
        logic [31:0]  junk;
        logic [255:0] elems_exp;
        w = ref_width(fmt);
        elems_exp = region;
        for (int b = 0; b < 256; b++)
            if (b >= 32*w) elems_exp[b] = 1'b0;
        exp_vec = {scale, elems_exp};
        junk = $urandom;
        send_word({junk[31:8], scale}, fmt, $urandom_range(0, gap_max));
        for (int j = 0; j < w; j++) begin
            check("early_valid", 264'(out_valid), 264'(0));
            // Format input wanders during element beats and must be ignored.
            send_word(region[32*j +: 32], 3'($urandom), $urandom_range(0, gap_max));
        end
        check("valid_after_last", 264'(out_valid), 264'(1));
        check("ready_in_full", 264'(in_ready), 264'(0));
        check("vector", out_vector, exp_vec);
        check("fmt", 264'(out_fmt), 264'(fmt));
        check("err", 264'(out_err), 264'(fmt > 3'd5));
    endtask

    // Hold off the consumer for hold cycles with an extra word offered,
    // then drain and confirm the loader reopens next cycle.
    task automatic drain(input int hold, input logic [263:0] exp_vec);
        in_valid  = 1'b1;
        in_data   = $urandom;
        out_ready = 1'b0;
        repeat (hold) begin
            tick();
            check("bp_in_ready", 264'(in_ready), 264'(0));
            check("bp_out_valid", 264'(out_valid), 264'(1));
            check("bp_stable", out_vector, exp_vec);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("drain_valid", 264'(out_valid), 264'(0));
        check("drain_ready", 264'(in_ready), 264'(1));
    endtask

    initial begin
        int           el[32];
        logic [255:0] region;
        logic [263:0] exp_vec;
        logic [2:0]   fmt;
        int           w;

        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_fmt    = '0;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_in_ready", 264'(in_ready), 264'(1));
        check("rst_out_valid", 264'(out_valid), 264'(0));
        check("rst_vector", out_vector, 264'(0));
        check("rst_fmt", 264'(out_fmt), 264'(0));
        check("rst_err", 264'(out_err), 264'(0));
        rst_n = 1'b1;
        tick();

        // INT8 block: element k = k, scale 0x7F, back-to-back beats.
        for (int k = 0; k < 32; k++) el[k] = k;
        region = pack_elems(el, 8);
        check("int8_beat0", 264'(region[31:0]), 264'(32'h03020100));
        send_block(8'h7F, 3'd5, region, 0, exp_vec);
        drain(2, exp_vec);

        // E2M1 block: four all-ones beats; garbage above must not appear.
        region = {128'($urandom), 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF};
        region[255:224] = 32'hDEAD_BEEF;
        send_block(8'h80, 3'd4, region, 0, exp_vec);
        check("e2m1_upper_zero", 264'(out_vector[255:128]), 264'(0));
        drain(4, exp_vec);

        // INT8 with nonzero data, then E3M2 must leave [255:192] clear.
        for (int k = 0; k < 32; k++) el[k] = 32'($urandom_range(1, 255));
        send_block(8'h11, 3'd5, pack_elems(el, 8), 1, exp_vec);
        drain(0, exp_vec);
        for (int k = 0; k < 32; k++) el[k] = 32'($urandom_range(0, 63));
        send_block(8'h22, 3'd2, pack_elems(el, 6), 1, exp_vec);
        check("e3m2_upper_zero", 264'(out_vector[255:192]), 264'(0));
        drain(1, exp_vec);

        // Long backpressure on an E5M2 block.
        for (int k = 0; k < 32; k++) el[k] = 32'($urandom_range(0, 255));
        send_block(8'h33, 3'd0, pack_elems(el, 8), 0, exp_vec);
        drain(10, exp_vec);

        // Illegal format 7: eight beats, err set, block still emitted.
        for (int k = 0; k < 32; k++) el[k] = 32'($urandom_range(0, 255));
        send_block(8'h44, 3'd7, pack_elems(el, 8), 0, exp_vec);
        drain(1, exp_vec);

        // Mid-block reset after beat 3 of an E4M3 block.
        send_word(32'h0000_0055, 3'd1, 0);
        for (int j = 0; j < 3; j++) send_word(32'hA5A5_A5A5, 3'd1, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mrst_out_valid", 264'(out_valid), 264'(0));
        check("mrst_in_ready", 264'(in_ready), 264'(1));
        check("mrst_vector", out_vector, 264'(0));
        for (int k = 0; k < 32; k++) el[k] = 32'($urandom_range(0, 255));
        send_block(8'h66, 3'd1, pack_elems(el, 8), 0, exp_vec);
        drain(0, exp_vec);

        // Randomized blocks: format, scale, elements, gaps and backpressure.
        for (int t = 0; t < 40; t++) begin
            fmt = 3'($urandom_range(0, 7));
            w   = ref_width(fmt);
            for (int k = 0; k < 32; k++) el[k] = 32'($urandom_range(0, (1 << w) - 1));
            send_block(8'($urandom), fmt, pack_elems(el, w), 2, exp_vec);
            drain($urandom_range(0, 3), exp_vec);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mx_vector_loader.md
# mx_vector_loader

Deserializing front-end for the MX ALU. Accepts a 32-bit valid/ready word stream carrying one MX block: a scale beat followed by densely packed element beats. Assembles the block into a single `LARGEST_VECTOR_SIZE`-bit (264-bit) vector that the ALU parses by format. One block is buffered at a time; output is presented with valid/ready and held until consumed.

## Interface
- `IN_WIDTH`, default 32: input word width. Only 32 is legal, since it equals `SCALING_BLOCK_SIZE`. Elaboration fails otherwise.
- `VEC_WIDTH`, default `LARGEST_VECTOR_SIZE` (264): output vector width. Not overridable.
- `clk` in 1: clock. Single clock domain.
- `rst_n` in 1: reset, synchronous and active-low.
- `in_valid` in 1: input word valid.
- `in_ready` out 1: loader can accept a word.
- `in_data` in 32: scale beat or element beat.
- `in_fmt` in 3: element format. Sampled only on the accepted scale beat.
- `out_valid` out 1: assembled vector available.
- `out_ready` in 1: consumer accepts the vector.
- `out_vector` out 264: bits [263:256] hold the scale; bits [255:0] hold the elements.
- `out_fmt` out 3: format latched with this vector.
- `out_err` out 1: latched format code was illegal.

## Operation
- Format codes:
  - 0 = E5M2, 1 = E4M3 (8 bits)
  - 2 = E3M2, 3 = E2M3 (6 bits)
  - 4 = E2M1 (4 bits)
  - 5 = INT8 (8 bits)
  - 6 and 7 are illegal: the block uses an 8-bit element width, sets `out_err`, and still accepts and emits the block.
- Block layout on the input: one scale beat (scale in `in_data[7:0]`, bits [31:8] ignored), then W element beats, where W is the element bit width. W is also the beat count because 32 elements × W bits / 32 = W.
- Element k occupies `out_vector[k*W +: W]`, i.e. LSB-first and contiguous. Beat j fills `out_vector[32*j +: 32]`.
- Element bits [255:32*W] read zero. They are cleared when the scale beat is accepted.
- FSM states:
  - SCALE: `in_ready`=1. On accept, latch scale, format and err; clear the element region; set beat counter to 0; go to ELEMS.
  - ELEMS: `in_ready`=1. On accept, write the beat at `32*cnt` and increment `cnt`. When `cnt`==W-1 on accept, go to FULL.
  - FULL: `in_ready`=0, `out_valid`=1. When `out_ready` is high, go to SCALE.
- `out_vector`, `out_fmt` and `out_err` are stable throughout FULL. Outside FULL they are don't-care, but are implemented as the live registers.
- `in_valid` without a handshake has no effect. Beats may arrive with arbitrary gaps.

## Timing
- Reset values:
  - state = SCALE, `cnt` = 0
  - `in_ready` = 1, `out_valid` = 0
  - `out_vector` = 0, `out_fmt` = 0, `out_err` = 0
- `in_ready` and `out_valid` are combinational from the state register only. No input-to-output combinational path.
- Latency: `out_valid` rises the cycle after the last element beat is accepted.
- Minimum period per block is W+2 cycles (scale + W beats + 1 FULL cycle with `out_ready`=1).
- An output handshake in FULL moves to SCALE next cycle. A scale beat is never accepted in the same cycle as an output handshake.
- `rst_n` low in any state, including mid-block, discards the partial vector and restores reset values at the next edge.
- `in_fmt` changes during ELEMS are ignored.

## Structure
- Add to `mx_format_pkg`:
  - `t_mx_format` enum (3 bits, codes above)
  - `mx_elem_bits(t_mx_format)` function returning 8/6/4, with 8 for illegal codes
  - `mx_fmt_legal()` function
- Keep the FSM state enum local to the module.
- No sub-module: one 264-bit register with an indexed 32-bit part-select write, a 3-bit counter and a 2-bit state.

## Test plan
- **INT8 block:** scale 0x7F, beats 0x03020100…0x1F1E1D1C → one vector with [263:256]=0x7F, element k = k, `out_fmt`=5, `out_err`=0, `out_valid` one cycle after beat 8.
- **E2M1 block:** scale 0x80, four beats 0xFFFFFFFF → [127:0] all ones, [255:128]=0, exactly 4 element beats consumed. A fifth word is not accepted until the vector is drained.
- **E3M2 after INT8:** after an INT8 block with nonzero data, a 6-beat E3M2 block → [255:192]=0, `out_fmt`=2.
- **Backpressure:** hold `out_ready`=0 for 10 cycles → `in_ready`=0 and `out_vector` stable throughout. Raise `out_ready` → `in_ready`=1 next cycle.
- **Illegal format:** `in_fmt`=7 → 8 element beats consumed, `out_err`=1, `out_fmt`=7.
- **Mid-block reset:** assert `rst_n`=0 after beat 3 of an E4M3 block → next cycle `out_valid`=0, `in_ready`=1. A following full block assembles correctly with no stale data.
